// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential nibble multiplier.
// Includes the FSM encoding, widths, partial-product shifts and the operand magnitude helper.
package mult_pkg;

   localparam int OPW  = 8;
   localparam int NIBW = 4;
   localparam int PW   = 16;

   localparam int SH_PP0 = 0;
   localparam int SH_PP1 = 4;
   localparam int SH_PP2 = 4;
   localparam int SH_PP3 = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PP0  = 3'd1,
      PP1  = 3'd2,
      PP2  = 3'd3,
      PP3  = 3'd4,
      FIN  = 3'd5,
      DONE = 3'd6
   } state_t;

   // -128 (8'h80) maps to 8'h80, which is still the correct unsigned magnitude.
   function automatic logic [OPW-1:0] operand_mag(input logic [OPW-1:0] x, input logic signed_mode);
      logic [OPW-1:0] mag;
      if (signed_mode && x[OPW-1]) begin
         mag = ~x + 8'd1;
      end else begin
         mag = x;
      end
      return mag;
   endfunction

endpackage

// File: rtl/nibble_mult_4x4.sv
// Combinational unsigned 4x4 -> 8 multiplier.
// A single copy is shared across all four partial products.
module nibble_mult_4x4
   import mult_pkg::*;
(
   input  logic [NIBW-1:0]   x,
   input  logic [NIBW-1:0]   y,
   output logic [2*NIBW-1:0] prod
);

   assign prod = (2*NIBW)'(x) * (2*NIBW)'(y);

endmodule

// File: rtl/nibble_mult_seq.sv
// Multi-cycle 8x8 multiplier that reuses one 4x4 nibble multiplier over four states.
// Operands and the product each use a valid/ready handshake; the sign is applied after accumulation.
module nibble_mult_seq
   import mult_pkg::*;
#(
   parameter bit SIGNED_MODE = 1'b1
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [PW-1:0]  p,
   output logic           busy
);

   state_t              state_r;
   logic [OPW-1:0]      mag_a_r;
   logic [OPW-1:0]      mag_b_r;
   logic                neg_r;
   logic [PW-1:0]       acc_r;
   logic [PW-1:0]       p_r;
   logic                out_valid_r;
   logic                in_ready_r;
   logic                busy_r;

   logic [NIBW-1:0]     nib_a_s;
   logic [NIBW-1:0]     nib_b_s;
   logic [2*NIBW-1:0]   pp_s;
   logic [PW-1:0]       pp_shift_s;

   // Select operand nibbles and the alignment of the current partial product.
   always_comb begin
      nib_a_s    = {NIBW{1'b0}};
      nib_b_s    = {NIBW{1'b0}};
      pp_shift_s = {PW{1'b0}};
      case (state_r)
         PP0: begin
            nib_a_s    = mag_a_r[3:0];
            nib_b_s    = mag_b_r[3:0];
            pp_shift_s = PW'(pp_s) << SH_PP0;
         end
         PP1: begin
            nib_a_s    = mag_a_r[7:4];
            nib_b_s    = mag_b_r[3:0];
            pp_shift_s = PW'(pp_s) << SH_PP1;
         end
         PP2: begin
            nib_a_s    = mag_a_r[3:0];
            nib_b_s    = mag_b_r[7:4];
            pp_shift_s = PW'(pp_s) << SH_PP2;
         end
         PP3: begin
            nib_a_s    = mag_a_r[7:4];
            nib_b_s    = mag_b_r[7:4];
            pp_shift_s = PW'(pp_s) << SH_PP3;
         end
         default: begin
            nib_a_s    = {NIBW{1'b0}};
            nib_b_s    = {NIBW{1'b0}};
            pp_shift_s = {PW{1'b0}};
         end
      endcase
   end

   nibble_mult_4x4 u_nib_mult (
      .x    (nib_a_s),
      .y    (nib_b_s),
      .prod (pp_s)
   );

   // Controller FSM: capture, accumulate, sign-correct and hold the product until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mag_a_r     <= {OPW{1'b0}};
         mag_b_r     <= {OPW{1'b0}};
         neg_r       <= 1'b0;
         acc_r       <= {PW{1'b0}};
         p_r         <= {PW{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  mag_a_r    <= operand_mag(a, SIGNED_MODE);
                  mag_b_r    <= operand_mag(b, SIGNED_MODE);
                  neg_r      <= SIGNED_MODE ? (a[OPW-1] ^ b[OPW-1]) : 1'b0;
                  acc_r      <= {PW{1'b0}};
                  state_r    <= PP0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            PP0: begin
               acc_r   <= acc_r + pp_shift_s;
               state_r <= PP1;
            end
            PP1: begin
               acc_r   <= acc_r + pp_shift_s;
               state_r <= PP2;
            end
            PP2: begin
               acc_r   <= acc_r + pp_shift_s;
               state_r <= PP3;
            end
            PP3: begin
               acc_r   <= acc_r + pp_shift_s;
               state_r <= FIN;
            end
            FIN: begin
               // A zero magnitude stays zero after negation, so neg needs no special case.
               p_r         <= neg_r ? (~acc_r + 16'd1) : acc_r;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign p         = p_r;
   assign busy      = busy_r;

endmodule
